// File: rtl/state_sequencer_pkg.sv
// Shared definitions for the state sequencer: state, scan direction and op_code encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package state_sequencer_pkg;

    // CORE_S must stay at encoding 0: it is the reset and fallback state.
    typedef enum logic [2:0] {
        CORE_S       = 3'd0,
        BRANCH_S     = 3'd1,
        CACHE_LOAD_S = 3'd2,
        CACHE_SAVE_S = 3'd3,
        POP_WRITE_S  = 3'd4
    } state_t;

    typedef enum logic {
        SCAN_FWD = 1'b0,
        SCAN_BWD = 1'b1
    } scan_dir_t;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_INC     = 3'd1,
        OP_DEC     = 3'd2,
        OP_LEFT    = 3'd3,
        OP_RIGHT   = 3'd4,
        OP_OUT     = 3'd5,
        LOOP_OPEN  = 3'd6,
        LOOP_CLOSE = 3'd7
    } op_code_t;

    localparam int CACHE_LINES_DEFAULT = 4;

endpackage

// File: rtl/state_sequencer_nest_counter.sv
// Loop-bracket nesting counter used by the branch scan; flags the matching bracket and overflow.
// Latency: match/overflow combinational from current depth; depth updates on the next edge.
// Backpressure: none; evaluates whenever enable is high.
// Ports: clk, reset_n (sync, active low), dir, instruction, enable, clear -> depth, match, overflow.
module state_sequencer_nest_counter
    import state_sequencer_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  scan_dir_t          dir,
    input  op_code_t           instruction,
    input  logic               enable,
    input  logic               clear,
    output logic [DEPTH_W-1:0] depth,
    output logic               match,
    output logic               overflow
);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               open_hit, close_hit;

    always_comb begin
        // "Open" is the bracket that nests deeper in the current scan direction.
        open_hit  = enable && (((dir == SCAN_FWD) && (instruction == LOOP_OPEN)) ||
                               ((dir == SCAN_BWD) && (instruction == LOOP_CLOSE)));
        close_hit = enable && (((dir == SCAN_FWD) && (instruction == LOOP_CLOSE)) ||
                               ((dir == SCAN_BWD) && (instruction == LOOP_OPEN)));
        overflow  = open_hit && (&depth_q);
        match     = close_hit && (depth_q == '0);

        depth_d = depth_q;
        if (clear) begin
            depth_d = '0;
        end else if (open_hit && !overflow) begin
            depth_d = depth_q + 1'b1;
        end else if (close_hit && !match) begin
            depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign depth = depth_q;

endmodule

// File: rtl/state_sequencer.sv
// Registered multi-cycle state tracker feeding control_unit.state_in; owns exits of branch/cache/pop states.
// Latency: state follows state_req one cycle after sampling in CORE_S; seq_done pulses in the first CORE_S cycle after a normal exit.
// Backpressure: cache states wait on mem_ack indefinitely unless SEQ_WATCHDOG_EN is defined (then bounded by WDOG_CYCLES).
// Ports: clk, reset_n (sync, active low), state_req, instruction, acc_zero, mem_ack ->
//        state, scan_dir, depth, cache_beat, mem_req, seq_done, depth_err, wdog_err.
// Optional feature macro: SEQ_WATCHDOG_EN (non-core state timeout).
module state_sequencer
    import state_sequencer_pkg::*;
#(
    parameter int DEPTH_W     = 8,
    parameter int CACHE_LINES = CACHE_LINES_DEFAULT,
    parameter int WDOG_CYCLES = 1024,
    localparam int BEAT_W     = (CACHE_LINES > 1) ? $clog2(CACHE_LINES) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  state_t             state_req,
    input  op_code_t           instruction,
    input  logic               acc_zero,
    input  logic               mem_ack,
    output state_t             state,
    output scan_dir_t          scan_dir,
    output logic [DEPTH_W-1:0] depth,
    output logic [BEAT_W-1:0]  cache_beat,
    output logic               mem_req,
    output logic               seq_done,
    output logic               depth_err,
    output logic               wdog_err
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CACHE_LINES - 1);

    state_t            state_q, state_d, state_nrm_d;
    scan_dir_t         scan_dir_q, scan_dir_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              seq_done_q, seq_done_d, seq_done_nrm_d;
    logic              depth_err_q, depth_err_d;
    logic              nest_en, nest_clear, nest_match, nest_overflow;
    logic              wdog_fire;

    // Branch decisions are made by the control unit before requesting BRANCH_S.
    logic unused_acc_zero;
    assign unused_acc_zero = acc_zero;

    state_sequencer_nest_counter #(.DEPTH_W(DEPTH_W)) u_nest (
        .clk         (clk),
        .reset_n     (reset_n),
        .dir         (scan_dir_q),
        .instruction (instruction),
        .enable      (nest_en),
        .clear       (nest_clear),
        .depth       (depth),
        .match       (nest_match),
        .overflow    (nest_overflow)
    );

    always_comb begin
        state_nrm_d    = state_q;
        scan_dir_d     = scan_dir_q;
        beat_d         = beat_q;
        seq_done_nrm_d = 1'b0;
        depth_err_d    = depth_err_q;
        nest_en        = 1'b0;
        nest_clear     = 1'b0;

        case (state_q)
            CORE_S: begin
                // Sanitise the request so an illegal encoding never reaches the state register.
                case (state_req)
                    CORE_S, BRANCH_S, CACHE_LOAD_S, CACHE_SAVE_S, POP_WRITE_S: state_nrm_d = state_req;
                    default:                                                   state_nrm_d = CORE_S;
                endcase
                if (state_nrm_d == BRANCH_S) begin
                    nest_clear = 1'b1;
                    scan_dir_d = (instruction == LOOP_OPEN) ? SCAN_FWD : SCAN_BWD;
                end
                if ((state_nrm_d == CACHE_LOAD_S) || (state_nrm_d == CACHE_SAVE_S)) begin
                    beat_d = '0;
                end
            end
            BRANCH_S: begin
                nest_en = 1'b1;
                if (nest_overflow) begin
                    // Abort the scan without signalling completion.
                    depth_err_d = 1'b1;
                    state_nrm_d = CORE_S;
                end else if (nest_match) begin
                    state_nrm_d    = CORE_S;
                    seq_done_nrm_d = 1'b1;
                end
            end
            CACHE_LOAD_S, CACHE_SAVE_S: begin
                if (mem_ack) begin
                    if (beat_q == LAST_BEAT) begin
                        state_nrm_d    = CORE_S;
                        seq_done_nrm_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            POP_WRITE_S: begin
                state_nrm_d    = CORE_S;
                seq_done_nrm_d = 1'b1;
            end
            default: state_nrm_d = CORE_S;
        endcase

        // A watchdog timeout overrides only a cycle that would otherwise stay non-core.
        state_d    = wdog_fire ? CORE_S : state_nrm_d;
        seq_done_d = seq_done_nrm_d && !wdog_fire;
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q;

    // Counter reads 0 in the first cycle of every non-core visit.
    always_comb begin
        wdog_cnt_d = (state_q == CORE_S) ? '0 : wdog_cnt_q + 1'b1;
        wdog_fire  = (state_q != CORE_S) && (state_nrm_d != CORE_S) && (wdog_cnt_q == WDOG_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            if (wdog_fire) begin
                wdog_err_q <= 1'b1;
            end
        end
    end

    assign wdog_err = wdog_err_q;
`else
    localparam int unused_wdog_cycles = WDOG_CYCLES;
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= CORE_S;
            scan_dir_q  <= SCAN_FWD;
            beat_q      <= '0;
            seq_done_q  <= 1'b0;
            depth_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_dir_q  <= scan_dir_d;
            beat_q      <= beat_d;
            seq_done_q  <= seq_done_d;
            depth_err_q <= depth_err_d;
        end
    end

    assign state      = state_q;
    assign scan_dir   = scan_dir_q;
    assign cache_beat = beat_q;
    assign mem_req    = (state_q == CACHE_LOAD_S) || (state_q == CACHE_SAVE_S);
    assign seq_done   = seq_done_q;
    assign depth_err  = depth_err_q;

endmodule

// File: tb/tb_state_sequencer.sv
module tb_state_sequencer;
    import state_sequencer_pkg::*;

    localparam int DW   = 2;
    localparam int CL   = 4;
    localparam int WDOG = 16;
    localparam int MAXD = (1 << DW) - 1;

    logic      clk = 1'b0;
    logic      reset_n;
    state_t    state_req;
    op_code_t  instruction;
    logic      acc_zero;
    logic      mem_ack;
    state_t    state;
    scan_dir_t scan_dir;
    logic [DW-1:0] depth;
    logic [1:0]    cache_beat;
    logic      mem_req, seq_done, depth_err, wdog_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    state_sequencer #(.DEPTH_W(DW), .CACHE_LINES(CL), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset_n(reset_n), .state_req(state_req), .instruction(instruction),
        .acc_zero(acc_zero), .mem_ack(mem_ack), .state(state), .scan_dir(scan_dir),
        .depth(depth), .cache_beat(cache_beat), .mem_req(mem_req), .seq_done(seq_done),
        .depth_err(depth_err), .wdog_err(wdog_err)
    );

    // ---------------- behavioural reference ----------------
    state_t m_state = CORE_S;
    bit     m_dir = 0, m_done = 0, m_derr = 0, m_werr = 0;
    int     m_depth = 0, m_beat = 0, m_visit = 0;

    task automatic model_step(input logic rst, input state_t req, input op_code_t ins, input logic ack);
        state_t nxt;
        bit deeper, shallower;
        if (!rst) begin
            m_state = CORE_S; m_dir = 0; m_depth = 0; m_beat = 0;
            m_done = 0; m_derr = 0; m_werr = 0; m_visit = 0;
            return;
        end
        m_done = 0;
        nxt = m_state;
        if (m_state == CORE_S) begin
            nxt = (req inside {CORE_S, BRANCH_S, CACHE_LOAD_S, CACHE_SAVE_S, POP_WRITE_S}) ? req : CORE_S;
            if (nxt == BRANCH_S) begin
                m_depth = 0;
                m_dir   = (ins == LOOP_OPEN) ? 0 : 1;
            end
            if (nxt == CACHE_LOAD_S || nxt == CACHE_SAVE_S) m_beat = 0;
            m_visit = 0;
        end else if (m_state == BRANCH_S) begin
            deeper    = (m_dir == 0) ? (ins == LOOP_OPEN)  : (ins == LOOP_CLOSE);
            shallower = (m_dir == 0) ? (ins == LOOP_CLOSE) : (ins == LOOP_OPEN);
            if (deeper) begin
                if (m_depth == MAXD) begin m_derr = 1; nxt = CORE_S; end
                else m_depth = m_depth + 1;
            end else if (shallower) begin
                if (m_depth == 0) begin nxt = CORE_S; m_done = 1; end
                else m_depth = m_depth - 1;
            end
        end else if (m_state == CACHE_LOAD_S || m_state == CACHE_SAVE_S) begin
            if (ack) begin
                if (m_beat == CL - 1) begin nxt = CORE_S; m_done = 1; end
                else m_beat = m_beat + 1;
            end
        end else begin
            nxt = CORE_S;
            m_done = (m_state == POP_WRITE_S);
        end
`ifdef SEQ_WATCHDOG_EN
        if (m_state != CORE_S) begin
            m_visit = m_visit + 1;
            if (nxt != CORE_S && m_visit >= WDOG) begin
                nxt = CORE_S; m_werr = 1; m_done = 0;
            end
        end
`endif
        m_state = nxt;
    endtask

    function automatic logic [11:0] model_pack();
        logic mreq;
        mreq = (m_state == CACHE_LOAD_S) || (m_state == CACHE_SAVE_S);
        return {m_state, m_dir, DW'(m_depth), 2'(m_beat), mreq, m_done, m_derr, m_werr};
    endfunction

    function automatic logic [11:0] dut_pack();
        return {state, scan_dir, depth, cache_beat, mem_req, seq_done, depth_err, wdog_err};
    endfunction

    task automatic chk(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%03h expected=%03h (state,dir,depth,beat,mreq,done,derr,werr)",
                     name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs away from the rising edge, advance the model, sample after the edge.
    task automatic cycle(input logic rst, input state_t req, input op_code_t ins, input logic ack);
        @(negedge clk);
        reset_n = rst; state_req = req; instruction = ins; mem_ack = ack;
        acc_zero = 1'($urandom_range(0, 1));
        model_step(rst, req, ins, ack);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        state_t      req;
        op_code_t    ins;
        logic        ack;
        logic [11:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic rst, input state_t req, input op_code_t ins, input logic ack,
                           input state_t st, input logic dir, input logic [DW-1:0] dep,
                           input logic [1:0] beat, input logic mreq, input logic done, input logic derr);
        vec_t v;
        v.rst = rst; v.req = req; v.ins = ins; v.ack = ack;
        v.exp = {st, dir, dep, beat, mreq, done, derr, 1'b0};
        vecs.push_back(v);
    endtask

    initial begin
        state_t bad_req;
        op_code_t r_ins;
        int r;
        bad_req = state_t'(3'd6);
        reset_n = 1'b0; state_req = BRANCH_S; instruction = LOOP_OPEN; mem_ack = 1'b0; acc_zero = 1'b0;

        // reset held with a branch request pending
        add_vec(0, BRANCH_S, LOOP_OPEN, 0,  CORE_S, 0, 0, 0, 0, 0, 0);
        add_vec(0, BRANCH_S, LOOP_OPEN, 0,  CORE_S, 0, 0, 0, 0, 0, 0);
        // forward scan: NOP, OPEN, NOP, CLOSE, CLOSE (state_req ignored meanwhile)
        add_vec(1, BRANCH_S, LOOP_OPEN, 0,      BRANCH_S, 0, 0, 0, 0, 0, 0);
        add_vec(1, CACHE_LOAD_S, OP_NOP, 1,     BRANCH_S, 0, 0, 0, 0, 0, 0);
        add_vec(1, CACHE_LOAD_S, LOOP_OPEN, 0,  BRANCH_S, 0, 1, 0, 0, 0, 0);
        add_vec(1, CORE_S, OP_NOP, 0,           BRANCH_S, 0, 1, 0, 0, 0, 0);
        add_vec(1, CORE_S, LOOP_CLOSE, 0,       BRANCH_S, 0, 0, 0, 0, 0, 0);
        add_vec(1, CORE_S, LOOP_CLOSE, 0,       CORE_S,   0, 0, 0, 0, 1, 0);
        add_vec(1, CORE_S, OP_NOP, 0,           CORE_S,   0, 0, 0, 0, 0, 0);
        // backward scan: CLOSE, OPEN, OPEN
        add_vec(1, BRANCH_S, LOOP_CLOSE, 0,     BRANCH_S, 1, 0, 0, 0, 0, 0);
        add_vec(1, POP_WRITE_S, LOOP_CLOSE, 0,  BRANCH_S, 1, 1, 0, 0, 0, 0);
        add_vec(1, CORE_S, LOOP_OPEN, 0,        BRANCH_S, 1, 0, 0, 0, 0, 0);
        add_vec(1, CORE_S, LOOP_OPEN, 0,        CORE_S,   1, 0, 0, 0, 1, 0);
        add_vec(1, CORE_S, OP_NOP, 0,           CORE_S,   1, 0, 0, 0, 0, 0);
        // cache load burst, acks on cycles 1,3,4,7
        add_vec(1, CACHE_LOAD_S, OP_NOP, 0,     CACHE_LOAD_S, 1, 0, 0, 1, 0, 0);
        add_vec(1, BRANCH_S, OP_NOP, 1,         CACHE_LOAD_S, 1, 0, 1, 1, 0, 0);
        add_vec(1, BRANCH_S, OP_NOP, 0,         CACHE_LOAD_S, 1, 0, 1, 1, 0, 0);
        add_vec(1, BRANCH_S, OP_NOP, 1,         CACHE_LOAD_S, 1, 0, 2, 1, 0, 0);
        add_vec(1, BRANCH_S, OP_NOP, 1,         CACHE_LOAD_S, 1, 0, 3, 1, 0, 0);
        add_vec(1, BRANCH_S, OP_NOP, 0,         CACHE_LOAD_S, 1, 0, 3, 1, 0, 0);
        add_vec(1, BRANCH_S, OP_NOP, 0,         CACHE_LOAD_S, 1, 0, 3, 1, 0, 0);
        add_vec(1, BRANCH_S, OP_NOP, 1,         CORE_S,       1, 0, 3, 0, 1, 0);
        add_vec(1, CORE_S, OP_NOP, 0,           CORE_S,       1, 0, 3, 0, 0, 0);
        // nesting overflow with a 2-bit depth counter
        add_vec(1, BRANCH_S, LOOP_OPEN, 0,      BRANCH_S, 0, 0, 3, 0, 0, 0);
        add_vec(1, CORE_S, LOOP_OPEN, 0,        BRANCH_S, 0, 1, 3, 0, 0, 0);
        add_vec(1, CORE_S, LOOP_OPEN, 0,        BRANCH_S, 0, 2, 3, 0, 0, 0);
        add_vec(1, CORE_S, LOOP_OPEN, 0,        BRANCH_S, 0, 3, 3, 0, 0, 0);
        add_vec(1, CORE_S, LOOP_OPEN, 0,        CORE_S,   0, 3, 3, 0, 0, 1);
        add_vec(1, CORE_S, OP_NOP, 0,           CORE_S,   0, 3, 3, 0, 0, 1);
        // single-cycle pop write, then an illegal request
        add_vec(1, POP_WRITE_S, OP_NOP, 0,      POP_WRITE_S, 0, 3, 3, 0, 0, 1);
        add_vec(1, BRANCH_S, OP_NOP, 0,         CORE_S,      0, 3, 3, 0, 1, 1);
        add_vec(1, bad_req, OP_NOP, 0,          CORE_S,      0, 3, 3, 0, 0, 1);
        add_vec(0, CORE_S, OP_NOP, 0,           CORE_S,      0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].req, vecs[i].ins, vecs[i].ack);
            chk("vec", i, dut_pack(), vecs[i].exp);
        end

        // reset in the middle of a scan aborts it with no completion pulse
        cycle(1, BRANCH_S, LOOP_OPEN, 0);  chk("midscan", 0, dut_pack(), model_pack());
        cycle(1, CORE_S, LOOP_OPEN, 0);    chk("midscan", 1, dut_pack(), model_pack());
        cycle(0, CORE_S, LOOP_CLOSE, 0);   chk("midscan", 2, dut_pack(), 12'h000);
        cycle(1, CORE_S, OP_NOP, 0);       chk("midscan", 3, dut_pack(), 12'h000);

        // burst with no acknowledge: unbounded wait, or a watchdog timeout
        cycle(1, CACHE_SAVE_S, OP_NOP, 0); chk("stall", 0, dut_pack(), model_pack());
        for (int i = 1; i <= 20; i++) begin
            cycle(1, CORE_S, OP_NOP, 0);
            chk("stall", i, dut_pack(), model_pack());
        end
`ifdef SEQ_WATCHDOG_EN
        chk("wdog_end", 0, {state, 7'b0, wdog_err, seq_done}, {CORE_S, 7'b0, 1'b1, 1'b0});
`else
        chk("stall_end", 0, {state, mem_req, wdog_err}, {CACHE_SAVE_S, 1'b1, 1'b0});
`endif
        cycle(1, CACHE_SAVE_S, OP_NOP, 0); chk("midburst", 0, dut_pack(), model_pack());
        cycle(1, CORE_S, OP_NOP, 1);       chk("midburst", 1, dut_pack(), model_pack());
        cycle(0, CORE_S, OP_NOP, 1);       chk("midburst", 2, dut_pack(), 12'h000);

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      r_ins = LOOP_OPEN;
            else if (r < 6) r_ins = LOOP_CLOSE;
            else            r_ins = op_code_t'(3'($urandom_range(0, 7)));
            cycle(($urandom_range(0, 63) != 0),
                  state_t'(3'($urandom_range(0, 7))),
                  r_ins,
                  ($urandom_range(0, 2) == 0));
            chk("rand", i, dut_pack(), model_pack());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
